// File: rtl/cache_port_arbiter_if.sv
// cache_port_arbiter_if: requester and cache-side signals of the cache port arbiter
interface cache_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int BVAL_W = 4
);
  logic              REQ0_RD, REQ1_RD, REQ0_WR, REQ1_WR;
  logic [ADDR_W-1:0] REQ0_ADDR, REQ1_ADDR;
  logic [DATA_W-1:0] REQ0_WDATA, REQ1_WDATA;
  logic [BVAL_W-1:0] REQ0_B_VAL, REQ1_B_VAL;
  logic              REQ0_ACK, REQ1_ACK, REQ0_ERR, REQ1_ERR;
  logic [DATA_W-1:0] REQ0_RDATA, REQ1_RDATA;
  logic [ADDR_W-1:0] CPU_ADDR;
  logic              SIG_CPU_RD, SIG_CPU_WR;
  logic [DATA_W-1:0] CPU_OUT_DATA;
  logic [BVAL_W-1:0] CPU_B_VAL;
  logic              ACK;
  logic [DATA_W-1:0] CPU_IN_DATA;
  logic              BUSY, GRANT;
  modport slave (
    input  REQ0_RD, REQ1_RD, REQ0_WR, REQ1_WR, REQ0_ADDR, REQ1_ADDR,
           REQ0_WDATA, REQ1_WDATA, REQ0_B_VAL, REQ1_B_VAL, ACK, CPU_IN_DATA,
    output REQ0_ACK, REQ1_ACK, REQ0_ERR, REQ1_ERR, REQ0_RDATA, REQ1_RDATA,
           CPU_ADDR, SIG_CPU_RD, SIG_CPU_WR, CPU_OUT_DATA, CPU_B_VAL, BUSY, GRANT
  );
  modport master (
    output REQ0_RD, REQ1_RD, REQ0_WR, REQ1_WR, REQ0_ADDR, REQ1_ADDR,
           REQ0_WDATA, REQ1_WDATA, REQ0_B_VAL, REQ1_B_VAL, ACK, CPU_IN_DATA,
    input  REQ0_ACK, REQ1_ACK, REQ0_ERR, REQ1_ERR, REQ0_RDATA, REQ1_RDATA,
           CPU_ADDR, SIG_CPU_RD, SIG_CPU_WR, CPU_OUT_DATA, CPU_B_VAL, BUSY, GRANT
  );
endinterface

// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: round-robin arbiter sharing one cache CPU port between two requesters
module cache_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int BVAL_W  = 4,
  parameter int TIMEOUT = 255
) (
  input logic CACHE_CLK,
  input logic CACHE_RESET,
  cache_port_arbiter_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, RESP} state_t;
  state_t state_q, state_d;
  logic rr_q, rr_d, gnt_q, gnt_d, wr_q, wr_d;
  logic rd_stb_q, rd_stb_d, wr_stb_q, wr_stb_d, busy_q, busy_d;
  logic ack0_q, ack0_d, ack1_q, ack1_d, err0_q, err0_d, err1_q, err1_d;
  logic [TW-1:0] timer_q, timer_d, tinc;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [BVAL_W-1:0] bval_q, bval_d;
  logic v0, v1, sel, sel_rd, sel_wr, done, fail, tmo;
  assign v0 = bus.REQ0_RD | bus.REQ0_WR;
  assign v1 = bus.REQ1_RD | bus.REQ1_WR;
  // rr_q holds the last granted index; on a tie the other one wins
  assign sel = v0 & v1 ? ~rr_q : v1;
  assign sel_rd = sel ? bus.REQ1_RD : bus.REQ0_RD;
  assign sel_wr = sel ? bus.REQ1_WR : bus.REQ0_WR;
  assign tinc = timer_q == TW'(TIMEOUT) ? timer_q : timer_q + 1'b1;
  assign tmo = tinc == TW'(TIMEOUT);
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    gnt_d = gnt_q;
    wr_d = wr_q;
    timer_d = timer_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    bval_d = bval_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    rd_stb_d = 1'b0;
    wr_stb_d = 1'b0;
    done = 1'b0;
    fail = 1'b0;
    case (state_q)
      IDLE: if (v0 | v1) begin
        gnt_d = sel;
        wr_d = sel_wr;
        addr_d = sel ? bus.REQ1_ADDR : bus.REQ0_ADDR;
        wdata_d = sel ? bus.REQ1_WDATA : bus.REQ0_WDATA;
        bval_d = sel ? bus.REQ1_B_VAL : bus.REQ0_B_VAL;
        state_d = sel_rd & sel_wr ? RESP : ISSUE;
        rd_stb_d = sel_rd & ~sel_wr;
        wr_stb_d = sel_wr & ~sel_rd;
        done = sel_rd & sel_wr;
        fail = sel_rd & sel_wr;
      end
      ISSUE: begin
        state_d = WAIT_HI;
        timer_d = '0;
      end
      WAIT_HI: begin
        timer_d = tinc;
        state_d = bus.ACK ? WAIT_LO : tmo ? RESP : WAIT_HI;
        done = ~bus.ACK & tmo;
        fail = ~bus.ACK & tmo;
        rdata0_d = bus.ACK & ~wr_q & ~gnt_q ? bus.CPU_IN_DATA : rdata0_q;
        rdata1_d = bus.ACK & ~wr_q & gnt_q ? bus.CPU_IN_DATA : rdata1_q;
      end
      WAIT_LO: begin
        timer_d = tinc;
        state_d = ~bus.ACK | tmo ? RESP : WAIT_LO;
        done = ~bus.ACK | tmo;
        fail = bus.ACK & tmo;
      end
      RESP: begin
        state_d = IDLE;
        rr_d = gnt_q;
      end
      default: state_d = IDLE;
    endcase
  end
  assign ack0_d = done & ~gnt_d;
  assign ack1_d = done & gnt_d;
  assign err0_d = fail & ~gnt_d;
  assign err1_d = fail & gnt_d;
  assign busy_d = state_d != IDLE;
  always_ff @(posedge CACHE_CLK or posedge CACHE_RESET)
    if (CACHE_RESET) begin
      state_q <= IDLE;
      rr_q <= 1'b1;
      gnt_q <= 1'b0;
      wr_q <= 1'b0;
      timer_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      bval_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      rd_stb_q <= 1'b0;
      wr_stb_q <= 1'b0;
      busy_q <= 1'b0;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      err0_q <= 1'b0;
      err1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      gnt_q <= gnt_d;
      wr_q <= wr_d;
      timer_q <= timer_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      bval_q <= bval_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      rd_stb_q <= rd_stb_d;
      wr_stb_q <= wr_stb_d;
      busy_q <= busy_d;
      ack0_q <= ack0_d;
      ack1_q <= ack1_d;
      err0_q <= err0_d;
      err1_q <= err1_d;
    end
  assign bus.REQ0_ACK = ack0_q;
  assign bus.REQ1_ACK = ack1_q;
  assign bus.REQ0_ERR = err0_q;
  assign bus.REQ1_ERR = err1_q;
  assign bus.REQ0_RDATA = rdata0_q;
  assign bus.REQ1_RDATA = rdata1_q;
  assign bus.CPU_ADDR = addr_q;
  assign bus.CPU_OUT_DATA = wdata_q;
  assign bus.CPU_B_VAL = bval_q;
  assign bus.SIG_CPU_RD = rd_stb_q;
  assign bus.SIG_CPU_WR = wr_stb_q;
  assign bus.BUSY = busy_q;
  assign bus.GRANT = gnt_q;
endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb_cache_port_arbiter: scoreboard bench with a simple cache responder model
module tb_cache_port_arbiter;
  localparam int AW = 16, DW = 32, BW = 4, TO = 8;
  logic CACHE_CLK = 1'b0;
  logic CACHE_RESET = 1'b1;
  always #5 CACHE_CLK = ~CACHE_CLK;
  cache_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .BVAL_W(BW)) bus();
  cache_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BVAL_W(BW), .TIMEOUT(TO)) dut (
    .CACHE_CLK(CACHE_CLK),
    .CACHE_RESET(CACHE_RESET),
    .bus(bus)
  );
  typedef struct {
    int port;
    bit err;
    bit strobe;
    bit wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] bval;
    logic [DW-1:0] rdata;
    int lat;
  } exp_t;
  exp_t sb[$];
  exp_t m_e;
  int m_p;
  int checks = 0, failures = 0, cyc = 0, stb_cnt = 0, stb_cyc = 0, hold = 2, hold_left = 0;
  bit hang = 0;
  logic [DW-1:0] cache_rdata = '0;
  logic [DW-1:0] model_rdata [2] = '{default: '0};
  logic [1:0] rec_op;
  logic [AW-1:0] rec_addr;
  logic [DW-1:0] rec_wdata;
  logic [BW-1:0] rec_bval;
  always @(posedge CACHE_CLK) cyc <= cyc + 1;
  task automatic check(input string tag, input longint got, input longint want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask
  task automatic clear_reqs();
    bus.REQ0_RD = 0; bus.REQ0_WR = 0; bus.REQ1_RD = 0; bus.REQ1_WR = 0;
  endtask
  task automatic drive(input int p, input bit rd, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BW-1:0] bv, input bit err,
                       input int lat, input logic [DW-1:0] rdat);
    exp_t e;
    if (p == 1) begin
      bus.REQ1_RD = rd; bus.REQ1_WR = wr; bus.REQ1_ADDR = a; bus.REQ1_WDATA = d; bus.REQ1_B_VAL = bv;
    end else begin
      bus.REQ0_RD = rd; bus.REQ0_WR = wr; bus.REQ0_ADDR = a; bus.REQ0_WDATA = d; bus.REQ0_B_VAL = bv;
    end
    e.port = p; e.err = err; e.strobe = !(rd && wr); e.wr = wr; e.addr = a;
    e.wdata = d; e.bval = bv; e.rdata = rdat; e.lat = lat;
    sb.push_back(e);
  endtask
  task automatic wait_done(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge CACHE_CLK);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge CACHE_CLK);
  endtask
  task automatic reset_env();
    clear_reqs();
    sb.delete();
    model_rdata = '{default: '0};
    stb_cnt = 0;
  endtask
  // cache responder: raises ACK at the strobe and holds it for 'hold' cycles
  initial begin
    bus.ACK = 0;
    bus.CPU_IN_DATA = '0;
    forever begin
      @(negedge CACHE_CLK);
      if (CACHE_RESET) begin
        bus.ACK = 0;
        hold_left = 0;
      end else if (bus.SIG_CPU_RD || bus.SIG_CPU_WR) begin
        stb_cnt++;
        stb_cyc = cyc;
        rec_op = {bus.SIG_CPU_RD, bus.SIG_CPU_WR};
        rec_addr = bus.CPU_ADDR;
        rec_wdata = bus.CPU_OUT_DATA;
        rec_bval = bus.CPU_B_VAL;
        if (!hang) begin
          bus.ACK = 1;
          bus.CPU_IN_DATA = cache_rdata;
          hold_left = hold;
        end
      end else if (hold_left > 1) hold_left--;
      else begin
        bus.ACK = 0;
        hold_left = 0;
      end
    end
  end
  initial forever begin
    @(negedge CACHE_CLK);
    if (!CACHE_RESET && (bus.REQ0_ACK || bus.REQ1_ACK || bus.REQ0_ERR || bus.REQ1_ERR)) begin
      if (sb.size() == 0) check("unexpected_ack", 1, 0);
      else begin
        m_e = sb.pop_front();
        m_p = bus.REQ1_ACK ? 1 : 0;
        check("ack_port", {bus.REQ1_ACK, bus.REQ0_ACK}, m_e.port == 1 ? 2 : 1);
        check("err", m_p == 1 ? bus.REQ1_ERR : bus.REQ0_ERR, m_e.err);
        check("other_err", m_p == 1 ? bus.REQ0_ERR : bus.REQ1_ERR, 0);
        check("grant", bus.GRANT, m_e.port);
        check("strobe_cycles", stb_cnt, m_e.strobe ? 1 : 0);
        if (m_e.strobe) begin
          check("strobe_op", rec_op, m_e.wr ? 1 : 2);
          check("cpu_addr", rec_addr, m_e.addr);
          check("cpu_bval", rec_bval, m_e.bval);
          if (m_e.wr) check("cpu_wdata", rec_wdata, m_e.wdata);
        end
        if (m_e.lat >= 0) check("latency", cyc - stb_cyc, m_e.lat);
        if (!m_e.err && !m_e.wr) model_rdata[m_e.port] = m_e.rdata;
        check("rdata0", bus.REQ0_RDATA, model_rdata[0]);
        check("rdata1", bus.REQ1_RDATA, model_rdata[1]);
        if (m_p == 1) begin bus.REQ1_RD = 0; bus.REQ1_WR = 0; end
        else begin bus.REQ0_RD = 0; bus.REQ0_WR = 0; end
        stb_cnt = 0;
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    clear_reqs();
    bus.REQ0_ADDR = '0; bus.REQ1_ADDR = '0; bus.REQ0_WDATA = '0; bus.REQ1_WDATA = '0;
    bus.REQ0_B_VAL = '0; bus.REQ1_B_VAL = '0;
    repeat (3) @(negedge CACHE_CLK);
    check("rst_rdata", {bus.REQ0_RDATA, bus.REQ1_RDATA}, 0);
    check("rst_ctl", {bus.REQ0_ACK, bus.REQ1_ACK, bus.REQ0_ERR, bus.REQ1_ERR, bus.SIG_CPU_RD,
                      bus.SIG_CPU_WR, bus.BUSY, bus.GRANT, bus.CPU_ADDR, bus.CPU_B_VAL}, 0);
    check("rst_wdata", bus.CPU_OUT_DATA, 0);
    CACHE_RESET = 0;
    @(negedge CACHE_CLK);
    cache_rdata = 32'h0000_0001;
    drive(0, 1, 0, 16'h0210, '0, 4'hF, 0, 3, 32'h0000_0001);
    wait_done(50);
    CACHE_RESET = 1;
    reset_env();
    repeat (2) @(negedge CACHE_CLK);
    CACHE_RESET = 0;
    @(negedge CACHE_CLK);
    cache_rdata = 32'hAAAA_0000;
    drive(0, 1, 0, 16'h0100, '0, 4'hF, 0, 3, 32'hAAAA_0000);
    drive(1, 0, 1, 16'h0104, 32'h1111_1111, 4'b1111, 0, 3, '0);
    wait_done(100);
    cache_rdata = 32'hBBBB_0001;
    drive(0, 1, 0, 16'h0108, '0, 4'hF, 0, 3, 32'hBBBB_0001);
    wait_done(50);
    cache_rdata = 32'hCCCC_0002;
    drive(1, 1, 0, 16'h0200, '0, 4'hF, 0, 3, 32'hCCCC_0002);
    drive(0, 0, 1, 16'h0204, 32'h2222_2222, 4'b0101, 0, 3, '0);
    wait_done(100);
    drive(1, 0, 1, 16'h123C, 32'hDEAD_BEEF, 4'b0011, 0, 3, '0);
    wait_done(50);
    hang = 1;
    drive(0, 1, 0, 16'h0300, '0, 4'hF, 1, 9, '0);
    wait_done(100);
    check("busy_after_timeout", bus.BUSY, 0);
    hang = 0;
    cache_rdata = 32'h0BAD_F00D;
    drive(0, 1, 0, 16'h0304, '0, 4'hF, 0, 3, 32'h0BAD_F00D);
    wait_done(50);
    drive(1, 1, 1, 16'h0400, '0, 4'hF, 1, -1, '0);
    wait_done(50);
    hold = 6;
    cache_rdata = 32'h5A5A_5A5A;
    drive(0, 1, 0, 16'h0500, '0, 4'hF, 0, -1, 32'h5A5A_5A5A);
    for (int n = 0; n < 20 && !bus.SIG_CPU_RD; n++) @(negedge CACHE_CLK);
    check("midrst_strobe", bus.SIG_CPU_RD, 1);
    repeat (2) @(negedge CACHE_CLK);
    check("midrst_captured", bus.REQ0_RDATA, 32'h5A5A_5A5A);
    #2 CACHE_RESET = 1;
    #1;
    check("midrst_busy", bus.BUSY, 0);
    check("midrst_rdata", bus.REQ0_RDATA, 0);
    check("midrst_ctl", {bus.REQ0_ACK, bus.REQ0_ERR, bus.GRANT, bus.CPU_ADDR}, 0);
    reset_env();
    hold = 2;
    repeat (2) @(negedge CACHE_CLK);
    CACHE_RESET = 0;
    @(negedge CACHE_CLK);
    cache_rdata = 32'h0000_00AB;
    drive(0, 1, 0, 16'h0600, '0, 4'hF, 0, 3, 32'h0000_00AB);
    drive(1, 0, 1, 16'h0604, 32'h3333_3333, 4'b1100, 0, 3, '0);
    wait_done(100);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
